// File: rtl/mem_ref_sequencer.sv
// mem_ref_sequencer: control-step FSM for fetch and ld/ldi/st/addi execute,
// with configurable memory wait states and run/stop back-to-back execution.
module mem_ref_sequencer #(
  parameter int         MEM_WAIT = 0,
  parameter logic [4:0] OP_LD    = 5'b00000,
  parameter logic [4:0] OP_LDI   = 5'b00001,
  parameter logic [4:0] OP_ST    = 5'b00010,
  parameter logic [4:0] OP_ADDI  = 5'b00011,
  parameter logic [4:0] ALU_ADD  = 5'b00011
) (
  input  logic       Clock,
  input  logic       clear,
  input  logic       run,
  input  logic [4:0] ir_op,
  output logic       PCout,
  output logic       MARin,
  output logic       IncPC,
  output logic       ZHighin,
  output logic       Zlowin,
  output logic       Zlowout,
  output logic       PCin,
  output logic       Read,
  output logic       Write,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Gra,
  output logic       Grb,
  output logic       Rin,
  output logic       Rout,
  output logic       BAOut,
  output logic       Yin,
  output logic       Cout,
  output logic [4:0] op,
  output logic [3:0] step,
  output logic       busy,
  output logic       instr_done,
  output logic       illegal
);
  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, IDLE, HALT} state_t;
  localparam logic [3:0] W = 4'(MEM_WAIT);
  state_t state, next;
  logic [3:0] cnt;
  logic [7:0] t;
  logic is_ld, is_ldi, is_st, is_addi, short_op, legal, first;
  assign is_ld    = ir_op == OP_LD;
  assign is_ldi   = ir_op == OP_LDI;
  assign is_st    = ir_op == OP_ST;
  assign is_addi  = ir_op == OP_ADDI;
  assign short_op = is_ldi | is_addi;
  assign legal    = is_ld | is_st | short_op;
  // counter is reloaded on every state change, so it equals W only in the first cycle of a held step
  assign first      = cnt == W;
  assign busy       = state != IDLE && state != HALT;
  assign illegal    = state == HALT;
  assign step       = busy ? state : 4'hF;
  assign t          = busy ? 8'b1 << state : 8'b0;
  assign instr_done = (t[5] & short_op) | (t[7] & (!is_st | cnt == 4'd0));
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= (next != state) ? W : (cnt != 4'd0 ? cnt - 4'd1 : 4'd0);
    end
  end
  always_comb begin
    next = state;
    if (instr_done) next = run ? T0 : IDLE;
    else case (state)
      IDLE:    next = run ? T0 : IDLE;
      T0:      next = T1;
      T1:      next = cnt == 4'd0 ? T2 : T1;
      T2:      next = T3;
      T3:      next = legal ? T4 : HALT;
      T4:      next = T5;
      T5:      next = T6;
      T6:      next = (is_st || cnt == 4'd0) ? T7 : T6;
      default: next = state;
    endcase
  end
  assign PCout   = t[0];
  assign IncPC   = t[0];
  assign ZHighin = t[0] | t[4];
  assign Zlowin  = t[0] | t[4];
  assign MARin   = t[0] | (t[5] & !short_op);
  assign Zlowout = (t[1] & first) | t[5];
  assign PCin    = t[1] & first;
  assign Read    = t[1] | (t[6] & !is_st);
  assign MDRin   = t[1] | t[6];
  assign Write   = t[7] & is_st;
  assign MDRout  = t[2] | (t[7] & !is_st);
  assign IRin    = t[2];
  assign Gra     = (t[5] & short_op) | (t[6] & is_st) | (t[7] & !is_st);
  assign Grb     = t[3] & legal;
  assign Rin     = (t[5] & short_op) | (t[7] & !is_st);
  assign Rout    = (t[3] & is_addi) | (t[6] & is_st);
  assign BAOut   = t[3] & legal & !is_addi;
  assign Yin     = t[3] & legal;
  assign Cout    = t[4];
  assign op      = t[4] ? ALU_ADD : 5'b00000;
endmodule

// File: tb/tb_mem_ref_sequencer.sv
// tb_mem_ref_sequencer: three sequencers (MEM_WAIT 0,1,2) driven by directed instructions;
// expected per-cycle output vectors are queued and a monitor checks every busy cycle.
module tb_mem_ref_sequencer;
  localparam int PCOUT = 18, MARIN = 17, INCPC = 16, ZHI = 15, ZLI = 14, ZLO = 13, PCIN = 12;
  localparam int RD = 11, WR = 10, MDRI = 9, MDRO = 8, IRI = 7, GRA = 6, GRB = 5, RIN = 4;
  localparam int ROUT = 3, BAO = 2, YIN = 1, COUT = 0;
  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_ADDI = 3, K_BAD = 4;
  localparam logic [30:0] IDLE_V = 31'h78, HALT_V = 31'h79;
  logic Clock = 0;
  logic clear = 1;
  logic [2:0] run = '0;
  logic [4:0] ir [3];
  wire [30:0] obs [3];
  logic [30:0] q [3][$];
  logic pb [3];
  int start [3], span [3];
  int cyc = 0, total = 0, bad = 0;
  always #5 Clock = ~Clock;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    mem_ref_sequencer #(.MEM_WAIT(g)) u (
      .Clock(Clock), .clear(clear), .run(run[g]), .ir_op(ir[g]),
      .PCout(obs[g][30]), .MARin(obs[g][29]), .IncPC(obs[g][28]), .ZHighin(obs[g][27]),
      .Zlowin(obs[g][26]), .Zlowout(obs[g][25]), .PCin(obs[g][24]), .Read(obs[g][23]),
      .Write(obs[g][22]), .MDRin(obs[g][21]), .MDRout(obs[g][20]), .IRin(obs[g][19]),
      .Gra(obs[g][18]), .Grb(obs[g][17]), .Rin(obs[g][16]), .Rout(obs[g][15]),
      .BAOut(obs[g][14]), .Yin(obs[g][13]), .Cout(obs[g][12]), .op(obs[g][11:7]),
      .step(obs[g][6:3]), .busy(obs[g][2]), .instr_done(obs[g][1]), .illegal(obs[g][0])
    );
  end
  always @(negedge Clock) begin
    logic [30:0] want;
    cyc++;
    for (int g = 0; g < 3; g++) begin
      if (obs[g][2] && !pb[g]) start[g] = cyc;
      if (obs[g][1]) span[g] = cyc - start[g] + 1;
      pb[g] = obs[g][2];
      if (obs[g][2]) begin
        total++;
        if (q[g].size() == 0) begin
          bad++;
          $display("FAIL busy_unexpected u%0d got=%h want=none", g, obs[g]);
        end else begin
          want = q[g].pop_front();
          if (obs[g] !== want) begin
            bad++;
            $display("FAIL cycle u%0d step=%0d got=%h want=%h", g, want[6:3], obs[g], want);
          end
        end
      end
    end
  end
  function automatic logic [18:0] b(int i);
    return 19'(1) << i;
  endfunction
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask
  task automatic chk(string n, logic [30:0] got, logic [30:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask
  task automatic chk_int(string n, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, got, want);
    end
  endtask
  task automatic push(int g, logic [18:0] m, logic [3:0] s, logic d);
    q[g].push_back({m, (s == 4'd4) ? 5'b00011 : 5'b00000, s, 1'b1, d, 1'b0});
  endtask
  task automatic expect_instr(int g, int k, int w);
    push(g, b(PCOUT) | b(MARIN) | b(INCPC) | b(ZHI) | b(ZLI), 0, 0);
    push(g, b(ZLO) | b(PCIN) | b(RD) | b(MDRI), 1, 0);
    repeat (w) push(g, b(RD) | b(MDRI), 1, 0);
    push(g, b(MDRO) | b(IRI), 2, 0);
    if (k == K_BAD) begin
      push(g, '0, 3, 0);
      return;
    end
    push(g, b(GRB) | b(YIN) | (k == K_ADDI ? b(ROUT) : b(BAO)), 3, 0);
    push(g, b(COUT) | b(ZHI) | b(ZLI), 4, 0);
    if (k == K_LDI || k == K_ADDI) begin
      push(g, b(ZLO) | b(GRA) | b(RIN), 5, 1);
      return;
    end
    push(g, b(ZLO) | b(MARIN), 5, 0);
    if (k == K_LD) begin
      repeat (w + 1) push(g, b(RD) | b(MDRI), 6, 0);
      push(g, b(MDRO) | b(GRA) | b(RIN), 7, 1);
    end else begin
      push(g, b(GRA) | b(ROUT) | b(MDRI), 6, 0);
      repeat (w) push(g, b(WR), 7, 0);
      push(g, b(WR), 7, 1);
    end
  endtask
  task automatic wait_idle(int g);
    int n = 0;
    while ((q[g].size() != 0 || obs[g][2]) && n < 200) begin
      tick();
      n++;
    end
    chk_int($sformatf("timeout_u%0d", g), int'(n < 200), 1);
  endtask
  task automatic go(int g, logic [4:0] opc, int k, int w);
    ir[g] = opc;
    expect_instr(g, k, w);
    run[g] = 1;
    tick();
    run[g] = 0;
    wait_idle(g);
  endtask
  initial begin
    for (int g = 0; g < 3; g++) begin
      ir[g] = 5'b00000;
      pb[g] = 0;
      start[g] = 0;
      span[g] = 0;
    end
    repeat (2) @(posedge Clock);
    #1;
    for (int g = 0; g < 3; g++) chk($sformatf("reset_u%0d", g), obs[g], IDLE_V);
    clear = 0;
    tick();
    ir[2] = 5'b00000;
    expect_instr(2, K_LD, 2);
    while (q[2].size() > 0 && q[2][$][6:3] >= 4'd4) void'(q[2].pop_back());
    run[2] = 1;
    tick();
    run[2] = 0;
    repeat (6) tick();
    clear = 1;
    #1;
    chk("clear_mid_t4", obs[2], IDLE_V);
    chk_int("clear_mid_t4_consumed", q[2].size(), 0);
    tick();
    clear = 0;
    repeat (3) tick();
    chk("idle_after_clear", obs[2], IDLE_V);
    go(0, 5'b00001, K_LDI, 0);
    chk_int("ldi_w0_latency", span[0], 6);
    chk("ldi_then_idle", obs[0], IDLE_V);
    go(2, 5'b00000, K_LD, 2);
    chk_int("ld_w2_latency", span[2], 12);
    go(1, 5'b00011, K_ADDI, 1);
    chk_int("addi_w1_latency", span[1], 7);
    ir[1] = 5'b00010;
    expect_instr(1, K_ST, 1);
    expect_instr(1, K_ST, 1);
    run[1] = 1;
    tick();
    for (int n = 0; n < 100 && q[1].size() > 10; n++) tick();
    run[1] = 0;
    wait_idle(1);
    chk_int("st_w1_back_to_back_span", span[1], 20);
    chk("st_then_idle", obs[1], IDLE_V);
    go(0, 5'b11111, K_BAD, 0);
    chk("halt", obs[0], HALT_V);
    run[0] = 1;
    repeat (3) tick();
    run[0] = 0;
    tick();
    chk("halt_ignores_run", obs[0], HALT_V);
    clear = 1;
    #1;
    chk("halt_clear", obs[0], IDLE_V);
    tick();
    clear = 0;
    tick();
    chk("idle_after_halt", obs[0], IDLE_V);
    for (int g = 0; g < 3; g++) chk_int($sformatf("queue_drained_u%0d", g), q[g].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
